// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [31:0] MEM1_ADDR_DEFAULT = 32'd2000;
  localparam logic [31:0] MEM2_ADDR_DEFAULT = 32'd2004;

  // Byte address to word index; callers truncate to their array width.
  function automatic logic [31:0] index_of(input logic [31:0] byte_addr);
    return byte_addr / WORD_BYTES;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Pipeline-to-data-memory request/response bundle.
interface data_mem_responder_if;
  logic        memread;
  logic        memwrite;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        resp_valid;
  logic        stall;
  logic        err;

  modport master (
    output memread, memwrite, address, writedata,
    input  readdata, resp_valid, stall, err
  );

  modport slave (
    input  memread, memwrite, address, writedata,
    output readdata, resp_valid, stall, err
  );
endinterface

// File: rtl/data_mem_responder_array.sv
// Single-port word array: synchronous write, registered read.
// The read register can be loaded from an external source so the top
// level can return zero on errors and the reset-cleared tap words.
module data_mem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic          ext_sel,
  input  logic [31:0]   ext_data,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Array storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  // Read register; holds its value between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= 32'd0;
    else if (re) rdata <= ext_sel ? ext_data : mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage.
//
//   state | meaning
//   IDLE  | waiting; stall follows the request combinationally
//   BUSY  | request latched; counting wait states, access when cnt = 0
//   RESP  | one-cycle completion: resp_valid, readdata, err valid
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] MEM1_ADDR   = MEM1_ADDR_DEFAULT,
  parameter logic [31:0] MEM2_ADDR   = MEM2_ADDR_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic [31:0]          mem1,
  output logic [31:0]          mem2
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q;
  logic [31:0]   addr_q, wdata_q;
  logic          wr_q, addr_bad_q, err_q;

  logic          req, addr_bad_in, err_in;
  logic          access, arr_we, arr_re, ext_sel;
  logic          hit1, hit2;
  logic [31:0]   ext_data, arr_rdata;
  logic [AW-1:0] arr_idx;
  logic          stall_c;

  assign req         = bus.memread | bus.memwrite;
  assign addr_bad_in = (bus.address[1:0] != 2'b00) |
                       ((bus.address >> (AW + 2)) != 32'd0);
  // Read+write together is treated as a write but still flagged.
  assign err_in      = addr_bad_in | (bus.memread & bus.memwrite);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and stall decode.
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = req;
        if (req) state_d = BUSY;
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt_q == 4'd0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and wait-state down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      addr_bad_q <= 1'b0;
      err_q      <= 1'b0;
    end else if (state_q == IDLE && req) begin
      cnt_q      <= 4'(WAIT_CYCLES);
      addr_q     <= bus.address;
      wdata_q    <= bus.writedata;
      wr_q       <= bus.memwrite;
      addr_bad_q <= addr_bad_in;
      err_q      <= err_in;
    end else if (state_q == BUSY && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign access  = (state_q == BUSY) && (cnt_q == 4'd0);
  // Gating with rst makes a reset coincident with the access edge win.
  assign arr_we  = access & wr_q & ~addr_bad_q & rst;
  assign arr_re  = access & (~wr_q | err_q);
  assign arr_idx = AW'(index_of(addr_q));
  assign hit1    = (addr_q == MEM1_ADDR);
  assign hit2    = (addr_q == MEM2_ADDR);
  // Tap words come from their registers so they read 0 after reset.
  assign ext_sel  = err_q | hit1 | hit2;
  assign ext_data = err_q ? 32'd0 : (hit1 ? mem1 : mem2);

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (arr_we),
    .re       (arr_re),
    .idx      (arr_idx),
    .wdata    (wdata_q),
    .ext_sel  (ext_sel),
    .ext_data (ext_data),
    .rdata    (arr_rdata)
  );

  // Tap registers track writes to the two shadowed words.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem1 <= 32'd0;
      mem2 <= 32'd0;
    end else if (arr_we) begin
      if (hit1) mem1 <= wdata_q;
      if (hit2) mem2 <= wdata_q;
    end
  end

  assign bus.stall      = stall_c;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.err        = (state_q == RESP) & err_q;
  assign bus.readdata   = arr_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with two wait states, one
// with zero wait states. Expected responses are queued at request time
// and consumed when resp_valid is seen.
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] mem1_a, mem2_a, mem1_b, mem2_b;

  int n_chk  = 0;
  int n_pass = 0;

  exp_t sb2[$];
  exp_t sb0[$];

  data_mem_responder_if bus2();
  data_mem_responder_if bus0();

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus2),
    .mem1 (mem1_a),
    .mem2 (mem2_a)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus0),
    .mem1 (mem1_b),
    .mem2 (mem2_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Response monitors.
  always @(negedge clk) begin
    if (bus2.resp_valid === 1'b1) begin
      if (sb2.size() == 0) begin
        chk("unexpected_resp2", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        if (e.chk_rd) chk("rdata2", bus2.readdata, e.rd);
        chk("err2", {31'd0, bus2.err}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    if (bus0.resp_valid === 1'b1) begin
      if (sb0.size() == 0) begin
        chk("unexpected_resp0", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb0.pop_front();
        if (e.chk_rd) chk("rdata0", bus0.readdata, e.rd);
        chk("err0", {31'd0, bus0.err}, {31'd0, e.err});
      end
    end
  end

  // Full request on the two-wait-state instance; entered and left just
  // after a rising edge with the DUT idle.
  task automatic op2(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input logic chk_rd);
    int stall_cnt;
    sb2.push_back('{rd: exp_rd, err: exp_err, chk_rd: chk_rd});
    bus2.memread   = rd;
    bus2.memwrite  = wr;
    bus2.address   = addr;
    bus2.writedata = wd;
    #1;
    stall_cnt = 0;
    while (bus2.stall === 1'b1 && stall_cnt < 40) begin
      stall_cnt++;
      @(posedge clk);
      #1;
    end
    chk("stall_len", stall_cnt, 32'd4);
    chk("resp_lat", {31'd0, bus2.resp_valid}, 32'd1);
    bus2.memread  = 1'b0;
    bus2.memwrite = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b0;
    bus2.memread = 1'b0; bus2.memwrite = 1'b0; bus2.address = '0; bus2.writedata = '0;
    bus0.memread = 1'b0; bus0.memwrite = 1'b0; bus0.address = '0; bus0.writedata = '0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    chk("rst_readdata", bus2.readdata, 32'd0);
    chk("rst_resp_valid", {31'd0, bus2.resp_valid}, 32'd0);
    chk("rst_err", {31'd0, bus2.err}, 32'd0);
    chk("rst_stall", {31'd0, bus2.stall}, 32'd0);
    chk("rst_mem1", mem1_a, 32'd0);
    chk("rst_mem2", mem2_a, 32'd0);

    // Write then read
    op2(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0);
    op2(1'b1, 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
    op2(1'b0, 1'b1, 32'h80, 32'h11111111, 32'd0, 1'b0, 1'b0);
    chk("rd_hold", bus2.readdata, 32'hDEADBEEF);

    // Taps
    op2(1'b0, 1'b1, 32'd2000, 32'h12345678, 32'd0, 1'b0, 1'b0);
    chk("tap1_set", mem1_a, 32'h12345678);
    chk("tap2_keep", mem2_a, 32'd0);
    op2(1'b0, 1'b1, 32'd2004, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    chk("tap2_set", mem2_a, 32'hCAFEF00D);
    chk("tap1_keep", mem1_a, 32'h12345678);
    op2(1'b0, 1'b1, 32'h84, 32'h0BADCAFE, 32'd0, 1'b0, 1'b0);
    chk("tap1_other", mem1_a, 32'h12345678);
    chk("tap2_other", mem2_a, 32'hCAFEF00D);
    op2(1'b1, 1'b0, 32'd2000, 32'd0, 32'h12345678, 1'b0, 1'b1);

    // Error cases
    op2(1'b0, 1'b1, 32'h42, 32'h000000BD, 32'd0, 1'b1, 1'b1);
    op2(1'b1, 1'b0, 32'h40, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
    op2(1'b1, 1'b0, 32'd4096, 32'd0, 32'd0, 1'b1, 1'b1);
    op2(1'b1, 1'b1, 32'h44, 32'h55AA55AA, 32'd0, 1'b1, 1'b1);
    op2(1'b1, 1'b0, 32'h44, 32'd0, 32'h55AA55AA, 1'b0, 1'b1);

    // Reset in the second BUSY cycle of a write to 0x80
    bus2.memwrite  = 1'b1;
    bus2.address   = 32'h80;
    bus2.writedata = 32'h22222222;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_rv", {31'd0, bus2.resp_valid}, 32'd0);
    bus2.memwrite = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, bus2.stall}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("postrst_rv", {31'd0, bus2.resp_valid}, 32'd0);
    end
    chk("postrst_mem1", mem1_a, 32'd0);
    op2(1'b1, 1'b0, 32'h80, 32'd0, 32'h11111111, 1'b0, 1'b1);
    op2(1'b1, 1'b0, 32'd2000, 32'd0, 32'd0, 1'b0, 1'b1);

    // Zero wait states, back-to-back, address disturbed during BUSY
    for (int k = 0; k < 12; k++) begin
      int ph;
      int n;
      ph = k % 3;
      n  = k / 3;
      if (ph == 0) begin
        bus0.memwrite  = (n < 2);
        bus0.memread   = (n >= 2);
        bus0.address   = 32'h100 + 32'(4 * (n % 2));
        bus0.writedata = 32'hA0000000 + 32'(n);
        sb0.push_back('{rd: 32'hA0000000 + 32'(n % 2), err: 1'b0, chk_rd: (n >= 2)});
      end else if (ph == 1) begin
        bus0.address   = 32'hFFFFFFF1;
        bus0.writedata = 32'd0;
      end
      #1;
      chk("z_stall", {31'd0, bus0.stall}, {31'd0, (ph != 2)});
      chk("z_resp", {31'd0, bus0.resp_valid}, {31'd0, (ph == 2)});
      @(posedge clk);
      #1;
    end
    bus0.memread  = 1'b0;
    bus0.memwrite = 1'b0;

    guard = 0;
    while ((sb2.size() != 0 || sb0.size() != 0) && guard < 20) begin
      guard++;
      @(posedge clk);
    end
    chk("sb2_drained", sb2.size(), 32'd0);
    chk("sb0_drained", sb0.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder for the 5-stage pipeline's MEM stage. It accepts read/write requests from the pipeline, models a configurable number of wait states and holds the pipeline with `stall` until each access completes. It returns read data with a one-cycle `resp_valid` pulse. Two fixed word locations are shadowed onto `mem1`/`mem2` for board/bench observation.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two.
- `WAIT_CYCLES`, 2: extra wait states per access; 0–15.
- `MEM1_ADDR`, 32'd2000: byte address shadowed on `mem1`; word-aligned.
- `MEM2_ADDR`, 32'd2004: byte address shadowed on `mem2`; word-aligned.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `memread` input 1: read request; held stable while `stall`=1.
- `memwrite` input 1: write request; held stable while `stall`=1.
- `address` input 32: byte address.
- `writedata` input 32: store data.
- `readdata` output 32: load data; valid when `resp_valid`=1.
- `resp_valid` output 1: one-cycle completion pulse for reads and writes.
- `stall` output 1: holds the PC, IF/ID and all pipeline registers.
- `err` output 1: completed access was misaligned or out of range; valid with `resp_valid`.
- `mem1`, `mem2` output 32: current contents of `MEM1_ADDR` and `MEM2_ADDR`.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - `req = memread | memwrite`.
  - `stall = req` (combinational).
  - When `req`=1, the next edge latches `address`, `writedata` and op, loads `cnt = WAIT_CYCLES`, and moves to BUSY.
- **BUSY**
  - `stall`=1.
  - When `cnt != 0`, decrement `cnt`.
  - When `cnt = 0`, perform the access at this edge and move to RESP.
  - Write: store the latched data to the array.
  - Read: register the array word into `readdata`.
- **RESP**
  - `stall`=0, `resp_valid`=1, `readdata` and `err` valid.
  - Next edge goes to IDLE unconditionally.
  - A new request is sampled only in the following IDLE cycle.
- **Addressing**
  - Word index is `address[log2(DEPTH_WORDS)+1:2]`.
  - `err` is set when `address[1:0] != 0` or `address[31:log2(DEPTH_WORDS)+2] != 0`.
  - On `err`, no write occurs and `readdata` = 0.
- If `memread` and `memwrite` are both 1, the access is a write and `err`=1.
- Inputs changing during BUSY are ignored; the latched request completes. Deasserting `req` mid-access does not abort it.
- `mem1`/`mem2` are registers updated at the same edge as any successful write to their address. They reflect the array contents at all times after reset.
- `readdata` holds its last value outside RESP.

## Timing
- Latency: request in cycle 0 (IDLE), access edge at end of cycle `WAIT_CYCLES+1`, RESP in cycle `WAIT_CYCLES+2`.
- `stall` is high for exactly `WAIT_CYCLES+2` cycles per request.
- Back-to-back requests have throughput of one access per `WAIT_CYCLES+3` cycles.
- Reset values: state=IDLE, `cnt`=0, `readdata`=0, `resp_valid`=0, `err`=0, `mem1`=0, `mem2`=0. `stall` = `req` combinationally.
- Array contents are not reset; they are undefined until written, except the two shadowed words, which read 0 after reset.
- Reset asserted during BUSY: the access is abandoned with no write, the FSM is in IDLE on release, and no `resp_valid` is produced.
- Reset asserted on the access edge: reset wins and no write occurs.

## Structure
- Package `mem_if_pkg`:
  - state enum {IDLE, BUSY, RESP};
  - `WORD_BYTES`=4;
  - default tap addresses 2000/2004;
  - `index_of()` helper.
- Sub-module `data_mem_array`: `DEPTH_WORDS`×32, synchronous write, registered read, one port, driven only on the access edge.
- Top level contains the FSM, wait counter, request latch, error check and tap registers.

## Test plan
- **Reset**: release `rst` with no request -> all outputs 0, `stall`=0 until `req`.
- **Write then read**, `WAIT_CYCLES`=2: write 0xDEADBEEF to 0x40 -> `stall` high 4 cycles then `resp_valid` pulse. Read 0x40 -> `readdata`=0xDEADBEEF with `resp_valid` in cycle 4, `err`=0.
- **Taps**: write 0x12345678 to 2000 and 0xCAFEF00D to 2004 -> `mem1`/`mem2` update on the access edge; other writes leave them unchanged.
- **Error cases**: write to 0x42 -> `err`=1, no write (read 0x40 is unchanged); read to `4*DEPTH_WORDS` -> `readdata`=0, `err`=1; both `memread` and `memwrite` set -> write performed, `err`=1.
- **Reset mid-op**: pull `rst` low in the second BUSY cycle of a write to 0x80 -> no `resp_valid`, location 0x80 retains its prior value, FSM returns to IDLE.
- **Zero wait**, `WAIT_CYCLES`=0 with back-to-back requests: `stall` high 2 cycles per access, `resp_valid` every 3rd cycle, and address changes during BUSY are ignored.
